// File: rtl/color_pkg.sv
// ---------------------------------------------------------------------------
// color_pkg
// Shared definitions for the colour-sense sequencer: the sequencer state
// enum, the TCS3200 filter-select codes driven on {s2,s3}, the LED index
// constants and the helper that rotates the LED index 1 -> 2 -> 3 -> 1.
// ---------------------------------------------------------------------------
package color_pkg;

  typedef enum logic [3:0] {
    IDLE,
    SET_R,
    CNT_R,
    SET_B,
    CNT_B,
    SET_G,
    CNT_G,
    DECIDE,
    EMIT
  } state_t;

  // Filter select codes, packed as {s2, s3}
  localparam logic [1:0] FILT_RED   = 2'b00;
  localparam logic [1:0] FILT_BLUE  = 2'b01;
  localparam logic [1:0] FILT_CLEAR = 2'b10;
  localparam logic [1:0] FILT_GREEN = 2'b11;

  // LED indices; zero is reserved for "no LED addressed"
  localparam logic [1:0] LED_IDX_1 = 2'd1;
  localparam logic [1:0] LED_IDX_2 = 2'd2;
  localparam logic [1:0] LED_IDX_3 = 2'd3;

  // Rotate the LED index, wrapping 3 back to 1 so zero never appears
  function automatic logic [1:0] next_led_idx(input logic [1:0] idx);
    logic [1:0] nxt;
    nxt = LED_IDX_1;
    if (idx == LED_IDX_1) nxt = LED_IDX_2;
    else if (idx == LED_IDX_2) nxt = LED_IDX_3;
    return nxt;
  endfunction

endpackage

// File: rtl/pulse_sync_edge.sv
// ---------------------------------------------------------------------------
// pulse_sync_edge
// Brings an asynchronous level into the clock domain through two flops and
// produces a registered single-cycle pulse on each synchronized rising edge.
// Total latency from the input edge to the pulse is 3 clock edges.
//
// Ports:
//   i_clk    system clock
//   i_rst    asynchronous active-high reset
//   i_async  asynchronous input level
//   o_pulse  one-cycle pulse per synchronized rising edge
// ---------------------------------------------------------------------------
module pulse_sync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic r_pulse;

  // Two-stage synchronizer, then compare against the previous synchronized
  // value; the pulse itself is registered so the output has no logic path
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_pulse <= r_sync2 & ~r_prev;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/color_sense_sequencer.sv
// ---------------------------------------------------------------------------
// color_sense_sequencer
// Steps a TCS3200-style sensor through its red, blue and green filters,
// counts sensor pulses over a fixed window for each, picks the dominant
// colour and emits a one-cycle colour strobe together with an LED index
// that rotates 1 -> 2 -> 3 on each successful detection.
//
// Ports:
//   i_clk           system clock
//   i_rst           asynchronous active-high reset
//   i_start         one-cycle reading request (only honoured when idle)
//   i_sensor_out    asynchronous sensor frequency output
//   o_s2, o_s3      filter select
//   o_red_out,
//   o_blue_out,
//   o_green_out     one-hot colour strobe, high only in EMIT
//   o_led_num       LED index during EMIT, zero otherwise
//   o_busy          high whenever a reading is in progress
//   o_no_color      one-cycle pulse when a reading misses the threshold
// ---------------------------------------------------------------------------
module color_sense_sequencer
  import color_pkg::*;
#(
  parameter int WINDOW_CYCLES = 50000,
  parameter int SETTLE_CYCLES = 500,
  parameter int MIN_COUNT     = 20,
  parameter int CNT_W         = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_sensor_out,
  output logic       o_s2,
  output logic       o_s3,
  output logic       o_red_out,
  output logic       o_blue_out,
  output logic       o_green_out,
  output logic [1:0] o_led_num,
  output logic       o_busy,
  output logic       o_no_color
);

  localparam logic [31:0]      SETTLE_LOAD = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0]      WINDOW_LOAD = 32'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           r_state;
  logic [31:0]      r_timer;
  logic [1:0]       r_idx;
  logic [1:0]       r_filt;
  logic [2:0]       r_strobe;
  logic [1:0]       r_led;
  logic             r_busy;
  logic             r_no_color;
  logic [CNT_W-1:0] r_cnt_r;
  logic [CNT_W-1:0] r_cnt_b;
  logic [CNT_W-1:0] r_cnt_g;

  logic             w_pulse;
  logic             w_timer_done;
  logic             w_red_win;
  logic             w_blue_win;
  logic [CNT_W-1:0] w_max;
  logic             w_valid;

  pulse_sync_edge u_sync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_sensor_out),
    .o_pulse (w_pulse)
  );

  assign w_timer_done = (r_timer == 32'd0);

  // Ties favour red over blue over green, hence >= in the comparisons
  assign w_red_win  = (r_cnt_r >= r_cnt_b) && (r_cnt_r >= r_cnt_g);
  assign w_blue_win = !w_red_win && (r_cnt_b >= r_cnt_g);
  assign w_max      = w_red_win ? r_cnt_r : (w_blue_win ? r_cnt_b : r_cnt_g);
  assign w_valid    = 32'(w_max) >= 32'(MIN_COUNT);

  // Pulse counters: cleared when a reading is accepted, each one only
  // counting while its own window is open, and holding at full scale
  // instead of wrapping so a very bright channel still wins
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt_r <= '0;
      r_cnt_b <= '0;
      r_cnt_g <= '0;
    end else if (r_state == IDLE && i_start) begin
      r_cnt_r <= '0;
      r_cnt_b <= '0;
      r_cnt_g <= '0;
    end else if (w_pulse) begin
      if (r_state == CNT_R && r_cnt_r != CNT_MAX) r_cnt_r <= r_cnt_r + CNT_ONE;
      if (r_state == CNT_B && r_cnt_b != CNT_MAX) r_cnt_b <= r_cnt_b + CNT_ONE;
      if (r_state == CNT_G && r_cnt_g != CNT_MAX) r_cnt_g <= r_cnt_g + CNT_ONE;
    end
  end

  // Sequencer: settle/count pairs per filter, then one decision cycle.
  // Outputs are registered alongside the state so they line up with it;
  // strobe, led index and no_color default low every cycle so they can
  // only ever last one cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_timer    <= 32'd0;
      r_idx      <= LED_IDX_1;
      r_filt     <= FILT_CLEAR;
      r_strobe   <= 3'b000;
      r_led      <= 2'd0;
      r_busy     <= 1'b0;
      r_no_color <= 1'b0;
    end else begin
      r_strobe   <= 3'b000;
      r_led      <= 2'd0;
      r_no_color <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state <= SET_R;
            r_timer <= SETTLE_LOAD;
            r_filt  <= FILT_RED;
            r_busy  <= 1'b1;
          end
        end
        SET_R, SET_B, SET_G: begin
          if (w_timer_done) begin
            r_state <= state_t'(r_state + 4'd1);
            r_timer <= WINDOW_LOAD;
          end else begin
            r_timer <= r_timer - 32'd1;
          end
        end
        CNT_R: begin
          if (w_timer_done) begin
            r_state <= SET_B;
            r_timer <= SETTLE_LOAD;
            r_filt  <= FILT_BLUE;
          end else begin
            r_timer <= r_timer - 32'd1;
          end
        end
        CNT_B: begin
          if (w_timer_done) begin
            r_state <= SET_G;
            r_timer <= SETTLE_LOAD;
            r_filt  <= FILT_GREEN;
          end else begin
            r_timer <= r_timer - 32'd1;
          end
        end
        CNT_G: begin
          if (w_timer_done) begin
            r_state <= DECIDE;
          end else begin
            r_timer <= r_timer - 32'd1;
          end
        end
        DECIDE: begin
          if (w_valid) begin
            r_state  <= EMIT;
            r_strobe <= {w_red_win, w_blue_win, !w_red_win && !w_blue_win};
            r_led    <= r_idx;
          end else begin
            r_state    <= IDLE;
            r_no_color <= 1'b1;
            r_busy     <= 1'b0;
            r_filt     <= FILT_CLEAR;
          end
        end
        EMIT: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_filt  <= FILT_CLEAR;
          r_idx   <= next_led_idx(r_idx);
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_filt  <= FILT_CLEAR;
        end
      endcase
    end
  end

  assign o_s2        = r_filt[1];
  assign o_s3        = r_filt[0];
  assign o_red_out   = r_strobe[2];
  assign o_blue_out  = r_strobe[1];
  assign o_green_out = r_strobe[0];
  assign o_led_num   = r_led;
  assign o_busy      = r_busy;
  assign o_no_color  = r_no_color;

endmodule

// File: tb/tb_color_sense_sequencer.sv
// ---------------------------------------------------------------------------
// tb_color_sense_sequencer
// Two sequencer instances (16-bit and 4-bit counters) share clock, reset
// and sensor line; 'sel' picks which one receives start and is observed.
// The sensor toggles with a half-period looked up from the observed s2/s3.
// The reference model timestamps every sampled rising edge of the sensor
// and counts, per filter, the edges whose detector pulse lands inside that
// filter's counting window measured from the cycle start was accepted.
// ---------------------------------------------------------------------------
module tb_color_sense_sequencer;

  localparam int W   = 100;
  localparam int S   = 10;
  localparam int MNC = 5;
  // Busy cycles from the accepting edge to the EMIT cycle
  localparam int LAT = 3 * (S + W) + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic sensor = 1'b0;
  bit   sel = 1'b0;

  logic startA, start4;
  logic aS2, aS3, aR, aB, aG, aBusy, aNc;
  logic bS2, bS3, bR, bB, bG, bBusy, bNc;
  logic [1:0] aLed, bLed;
  logic oS2, oS3, oR, oB, oG, oBusy, oNc;
  logic [1:0] oLed;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int edgeQ[$];
  logic prevS = 1'b0;
  int hp[4];
  int togCnt = 0;
  int idxModel[2];

  assign startA = start & ~sel;
  assign start4 = start & sel;
  assign oS2   = sel ? bS2 : aS2;
  assign oS3   = sel ? bS3 : aS3;
  assign oR    = sel ? bR : aR;
  assign oB    = sel ? bB : aB;
  assign oG    = sel ? bG : aG;
  assign oBusy = sel ? bBusy : aBusy;
  assign oNc   = sel ? bNc : aNc;
  assign oLed  = sel ? bLed : aLed;

  color_sense_sequencer #(.WINDOW_CYCLES(W), .SETTLE_CYCLES(S), .MIN_COUNT(MNC), .CNT_W(16)) dutA (
    .i_clk(clk), .i_rst(rst), .i_start(startA), .i_sensor_out(sensor),
    .o_s2(aS2), .o_s3(aS3), .o_red_out(aR), .o_blue_out(aB), .o_green_out(aG),
    .o_led_num(aLed), .o_busy(aBusy), .o_no_color(aNc)
  );

  color_sense_sequencer #(.WINDOW_CYCLES(W), .SETTLE_CYCLES(S), .MIN_COUNT(MNC), .CNT_W(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_start(start4), .i_sensor_out(sensor),
    .o_s2(bS2), .o_s3(bS3), .o_red_out(bR), .o_blue_out(bB), .o_green_out(bG),
    .o_led_num(bLed), .o_busy(bBusy), .o_no_color(bNc)
  );

  always #5 clk = ~clk;

  // Sensor model: toggles every hp[{s2,s3}] cycles, held low when zero
  always @(negedge clk) begin
    int h;
    h = hp[{oS2, oS3}];
    if (h == 0) begin
      sensor = 1'b0;
      togCnt = 0;
    end else begin
      togCnt = togCnt + 1;
      if (togCnt >= h) begin
        sensor = ~sensor;
        togCnt = 0;
      end
    end
  end

  // Timestamp every rising edge as seen at the sampling clock edge
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (sensor && !prevS) edgeQ.push_back(cyc);
    prevS = sensor;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_busy"}, oBusy, 0);
    checkOutput({tag, "_filter"}, {oS2, oS3}, 2'b10);
    checkOutput({tag, "_strobe"}, {oR, oB, oG}, 0);
    checkOutput({tag, "_led"}, oLed, 0);
    checkOutput({tag, "_noColor"}, oNc, 0);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idxModel[0] = 1;
    idxModel[1] = 1;
  endtask

  // Edges whose detector pulse (sample cycle + 2) falls inside filter f's window
  function automatic int countWin(input int k, input int f);
    int lo, n;
    n = 0;
    lo = k + f * (S + W) + S;
    foreach (edgeQ[i]) if (edgeQ[i] + 2 >= lo && edgeQ[i] + 2 <= lo + W - 1) n++;
    return n;
  endfunction

  task automatic applyStimulus(input int hR, input int hB, input int hG, input bit spam, input int rstAt);
    int k, evtCyc, cap, cR, cB, cG, best;
    bit done, aborted, valid, busySeen;
    logic [2:0] gotVec, expVec;
    logic [1:0] gotLed;
    logic gotNc, gotBusy;
    hp[0] = hR; hp[1] = hB; hp[3] = hG; hp[2] = 3;
    repeat ($urandom_range(1, 4)) @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 k = cyc;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busyOnStart", oBusy, 1);
    checkOutput("filterRedOnStart", {oS2, oS3}, 2'b00);
    done = 0; aborted = 0; evtCyc = 0;
    gotVec = 0; gotLed = 0; gotNc = 0; gotBusy = 0;
    for (int c = 0; c < LAT + 60 && !done; c++) begin
      if (c > 0) @(negedge clk);
      if (spam) start = (cyc - k < 300) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (rstAt > 0 && cyc - k == rstAt) begin
        rst = 1'b1;
        #1 checkReset("midReset");
        @(negedge clk);
        rst = 1'b0;
        idxModel[0] = 1;
        idxModel[1] = 1;
        aborted = 1;
      end
      if (oR || oB || oG || oNc) begin
        evtCyc = cyc; gotVec = {oR, oB, oG}; gotLed = oLed; gotNc = oNc; gotBusy = oBusy;
        done = 1;
      end
    end
    start = 1'b0;
    if (aborted) begin
      checkOutput("noStrobeAfterAbort", done, 0);
      return;
    end
    checkOutput("eventSeen", done, 1);
    if (!done) return;
    cap = sel ? 15 : 65535;
    cR = countWin(k, 0); cB = countWin(k, 1); cG = countWin(k, 2);
    if (cR > cap) cR = cap;
    if (cB > cap) cB = cap;
    if (cG > cap) cG = cap;
    if (cR >= cB && cR >= cG) begin best = cR; expVec = 3'b100; end
    else if (cB >= cG) begin best = cB; expVec = 3'b010; end
    else begin best = cG; expVec = 3'b001; end
    valid = best >= MNC;
    checkOutput("latency", evtCyc - k, LAT);
    if (valid) begin
      checkOutput("strobe", gotVec, expVec);
      checkOutput("ledNum", gotLed, idxModel[sel]);
      checkOutput("noColorLow", gotNc, 0);
      checkOutput("busyInEmit", gotBusy, 1);
      idxModel[sel] = (idxModel[sel] == 3) ? 1 : idxModel[sel] + 1;
    end else begin
      checkOutput("noColor", gotNc, 1);
      checkOutput("strobeOnNoColor", gotVec, 0);
      checkOutput("ledOnNoColor", gotLed, 0);
    end
    @(negedge clk);
    checkOutput("pulseOneCycle", {oR, oB, oG, oNc}, 0);
    checkOutput("ledCleared", oLed, 0);
    checkOutput("idleAfter", oBusy, 0);
    if (spam) begin
      busySeen = 0;
      repeat (20) begin
        @(negedge clk);
        busySeen |= oBusy;
      end
      checkOutput("startNotQueued", busySeen, 0);
    end
  endtask

  initial begin
    hp[0] = 0; hp[1] = 0; hp[2] = 3; hp[3] = 0;
    idxModel[0] = 1;
    idxModel[1] = 1;
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkReset("reset");
    rst = 1'b0;

    // Red dominant, first reading
    applyStimulus(2, 10, 10, 0, 0);

    // Fresh index: green, blue, red, then a fourth reading wraps
    pulseReset();
    applyStimulus(10, 10, 2, 0, 0);
    applyStimulus(10, 2, 10, 0, 0);
    applyStimulus(2, 10, 10, 0, 0);
    applyStimulus(10, 10, 3, 0, 0);

    // Dark sensor after reset: no colour, index untouched
    pulseReset();
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(2, 10, 10, 0, 0);

    // Red/blue tie at 10 edges each, green 5
    applyStimulus(5, 5, 10, 0, 0);

    // Start hammered while busy
    applyStimulus(2, 10, 10, 1, 0);

    // Reset in the middle of the blue window, then a clean reading
    applyStimulus(2, 10, 10, 0, 2 * S + W + 50);
    applyStimulus(10, 2, 10, 0, 0);

    // Random filter brightness
    repeat (8) applyStimulus($urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 12), 0, 0);

    // Narrow counters: red saturates at 15 and must still beat blue
    sel = 1'b1;
    applyStimulus(1, 4, 0, 0, 0);
    checkOutput("satCount", 32'(dut4.r_cnt_r), 15);
    repeat (2) applyStimulus($urandom_range(1, 6), $urandom_range(1, 6), $urandom_range(1, 6), 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
